// File: rtl/timer_sched.sv
// timer_sched: round-robin arbiter that shares one timer0 one-shot delay
// among N requesters. The granted requester's delay is written to the
// timer, the timer is enabled, the control register is polled until the
// done flag appears, the timer is disabled and a one-cycle done pulse is
// returned to the requester.
//
// Optional feature macro: TIMER_SCHED_TIMEOUT_EN
//   defined   -> polling gives up after MAX_POLLS reads; err pulses with done
//   undefined -> polling is unbounded, err is tied low
//
// Every output is a register loaded from the next-state decode, so bus
// signals change only on clock edges and stay stable while a write stalls.

module timer_sched #(
   parameter int          N          = 4,
   parameter logic [31:0] CTRL_ADDR  = 32'h0000_0000,
   parameter logic [31:0] DELAY_ADDR = 32'h0000_0004,
   parameter int          EN_BIT     = 0,
   parameter int          DONE_BIT   = 2,
   parameter logic [15:0] MAX_POLLS  = 16'hFFFF
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N-1:0]    req,
   input  logic [32*N-1:0] req_delay,
   output logic [N-1:0]    done,
   output logic            err,
   output logic            busy,
   output logic [2:0]      grant_id,
   output logic [31:0]     waddr,
   output logic [31:0]     wdata,
   output logic            wen,
   output logic [3:0]      wstrb,
   input  logic            wready,
   output logic [31:0]     raddr,
   output logic            ren,
   input  logic [31:0]     rdata,
   input  logic            rvalid
);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      WR_DLY,
      WR_EN,
      RD_REQ,
      RD_WAIT,
      WR_DIS,
      DONE
   } state_t;

   state_t        state_reg;
   state_t        state_next;

   // Last granted index; the search for the next winner starts one above it.
   logic [2:0]    rr_ptr_reg;
   logic [31:0]   delay_reg;

   // Arbitration result, valid while in IDLE.
   logic          arb_found;
   logic [2:0]    arb_idx;
   logic [31:0]   arb_delay;

   logic [N-1:0]  grant_onehot;

   // Next values of the registered outputs.
   logic [N-1:0]  done_next;
   logic          err_next;
   logic          busy_next;
   logic [31:0]   waddr_next;
   logic [31:0]   wdata_next;
   logic          wen_next;
   logic [3:0]    wstrb_next;
   logic [31:0]   raddr_next;
   logic          ren_next;

   // Only the done flag is of interest in the read data.
   logic          rdata_unused;
   assign rdata_unused = ^rdata;

   logic          poll_timeout;

`ifdef TIMER_SCHED_TIMEOUT_EN
   logic [15:0]   poll_cnt_reg;
   logic          timeout_reg;

   // Give up polling once MAX_POLLS reads have returned without done.
   assign poll_timeout = (poll_cnt_reg >= MAX_POLLS);

   // Poll counter and sticky timeout flag, both restarted on every grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         poll_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         if (state_reg == GRANT) begin
            poll_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
         end else if (state_reg == RD_REQ) begin
            poll_cnt_reg <= poll_cnt_reg + 16'd1;
         end else if (state_reg == RD_WAIT && rvalid && !rdata[DONE_BIT] && poll_timeout) begin
            timeout_reg  <= 1'b1;
         end
      end
   end
`else
   logic [15:0]   max_polls_unused;
   assign max_polls_unused = MAX_POLLS;
   assign poll_timeout     = 1'b0;
`endif

   // One-hot decode of the granted index, used for the done pulse.
   for (genvar gi = 0; gi < N; gi++) begin : g_grant_dec
      assign grant_onehot[gi] = (grant_id == 3'(gi));
   end

   // Round-robin search starting just above the last granted index.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_delay = '0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!arb_found && req[i] && (i == (int'(rr_ptr_reg) + k) % N)) begin
               arb_found = 1'b1;
               arb_idx   = 3'(i);
               arb_delay = req_delay[32*i +: 32];
            end
         end
      end
   end

   // Next-state decode and the output values belonging to the next state.
   always_comb begin
      state_next = state_reg;
      done_next  = '0;
      err_next   = 1'b0;
      busy_next  = 1'b0;
      waddr_next = '0;
      wdata_next = '0;
      wen_next   = 1'b0;
      wstrb_next = '0;
      raddr_next = '0;
      ren_next   = 1'b0;

      case (state_reg)
         IDLE:    if (arb_found) state_next = GRANT;
         GRANT:   state_next = (delay_reg == 32'd0) ? DONE : WR_DLY;
         WR_DLY:  if (wready) state_next = WR_EN;
         WR_EN:   if (wready) state_next = RD_REQ;
         RD_REQ:  state_next = RD_WAIT;
         RD_WAIT: begin
            if (rvalid) begin
               if (rdata[DONE_BIT] || poll_timeout) state_next = WR_DIS;
               else                                 state_next = RD_REQ;
            end
         end
         WR_DIS:  if (wready) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      case (state_next)
         WR_DLY: begin
            wen_next   = 1'b1;
            waddr_next = DELAY_ADDR;
            wdata_next = delay_reg;
         end
         WR_EN: begin
            wen_next   = 1'b1;
            waddr_next = CTRL_ADDR;
            wdata_next = 32'd1 << EN_BIT;
         end
         RD_REQ: begin
            ren_next   = 1'b1;
            raddr_next = CTRL_ADDR;
         end
         WR_DIS: begin
            wen_next   = 1'b1;
            waddr_next = CTRL_ADDR;
            wdata_next = 32'd0;
         end
         DONE: begin
            done_next = grant_onehot;
`ifdef TIMER_SCHED_TIMEOUT_EN
            err_next  = timeout_reg;
`endif
         end
         default: ;
      endcase

      busy_next  = (state_next != IDLE) && (state_next != DONE);
      wstrb_next = wen_next ? 4'hF : 4'h0;
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Grant capture on leaving IDLE; pointer advance when the sequence ends.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant_id   <= '0;
         delay_reg  <= '0;
         rr_ptr_reg <= 3'(N - 1);
      end else begin
         if (state_reg == IDLE && arb_found) begin
            grant_id  <= arb_idx;
            delay_reg <= arb_delay;
         end
         if (state_reg == DONE) begin
            rr_ptr_reg <= grant_id;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done  <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         wen   <= 1'b0;
         wstrb <= '0;
         raddr <= '0;
         ren   <= 1'b0;
      end else begin
         done  <= done_next;
         err   <= err_next;
         busy  <= busy_next;
         waddr <= waddr_next;
         wdata <= wdata_next;
         wen   <= wen_next;
         wstrb <= wstrb_next;
         raddr <= raddr_next;
         ren   <= ren_next;
      end
   end

endmodule

// File: tb/tb_timer_sched.sv
// Testbench for timer_sched: a small timer model answers the register bus,
// expected writes and completions are queued when requests are raised and
// compared when the DUT produces them.

module tb_timer_sched;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_delay;
   logic [N-1:0]    done;
   logic            err;
   logic            busy;
   logic [2:0]      grant_id;
   logic [31:0]     waddr;
   logic [31:0]     wdata;
   logic            wen;
   logic [3:0]      wstrb;
   logic            wready;
   logic [31:0]     raddr;
   logic            ren;
   logic [31:0]     rdata;
   logic            rvalid;

   // Bench controls.
   logic            bp_mode;
   logic            never_done;

   timer_sched #(.N(N), .MAX_POLLS(16'd4)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_delay(req_delay),
      .done(done), .err(err), .busy(busy), .grant_id(grant_id),
      .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
      .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid)
   );

   always #5 clk = ~clk;

   // Timer model: delay register, enable, down-counter, done flag.
   logic        t_en;
   logic [31:0] t_dly;
   logic [31:0] t_cnt;
   logic [2:0]  wait_cnt;

   assign wready = !bp_mode || (wait_cnt == 3'd3);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         t_en     <= 1'b0;
         t_dly    <= '0;
         t_cnt    <= '0;
         rvalid   <= 1'b0;
         rdata    <= '0;
         wait_cnt <= '0;
      end else begin
         rvalid <= ren;
         rdata  <= {29'd0, (t_en && t_cnt == 32'd0 && !never_done), 1'b0, t_en};
         if (wen && !wready) wait_cnt <= wait_cnt + 3'd1;
         else                wait_cnt <= '0;
         if (wen && wready) begin
            if (waddr == 32'h4) t_dly <= wdata;
            else if (waddr == 32'h0) begin
               t_en  <= wdata[0];
               t_cnt <= t_dly;
            end
         end else if (t_en && t_cnt != 32'd0) begin
            t_cnt <= t_cnt - 32'd1;
         end
      end
   end

   // Scoreboard.
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { int id; logic err; } dn_t;
   typedef struct { int id; logic [31:0] dly; logic bp; } vec_t;

   wr_t exp_wr[$];
   dn_t exp_done[$];

   int n_pass   = 0;
   int n_total  = 0;
   int done_cnt = 0;
   int rd_cnt   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push_seq(input int id, input logic [31:0] dly, input logic e);
      if (dly != 32'd0) begin
         exp_wr.push_back('{addr: 32'h4, data: dly});
         exp_wr.push_back('{addr: 32'h0, data: 32'h1});
         exp_wr.push_back('{addr: 32'h0, data: 32'h0});
      end
      exp_done.push_back('{id: id, err: e});
   endtask

   task automatic wait_done(input int target);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (done_cnt < target && k < 3000);
      if (done_cnt < target) check("done_wait_bound", 32'(done_cnt), 32'(target));
   endtask

   // Monitor: bus rules, write/read transactions and completion pulses.
   initial begin
      wr_t         e;
      dn_t         d;
      logic        prev_pend;
      logic [31:0] prev_addr;
      logic [31:0] prev_data;
      logic [N-1:0] prev_done;
      logic [N-1:0] m;
      prev_pend = 1'b0;
      prev_addr = '0;
      prev_data = '0;
      prev_done = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_pend = 1'b0;
            prev_done = '0;
         end else begin
            if (wen || ren) check("wen_ren_exclusive", 32'(wen && ren), 32'd0);
            if (wen) check("wstrb", 32'(wstrb), 32'hF);
            if (prev_pend) begin
               check("wen_hold", 32'(wen), 32'd1);
               check("waddr_hold", waddr, prev_addr);
               check("wdata_hold", wdata, prev_data);
            end
            prev_pend = wen && !wready;
            prev_addr = waddr;
            prev_data = wdata;
            if (wen && wready) begin
               if (exp_wr.size() == 0) begin
                  check("write_expected", 32'd0, 32'd1);
               end else begin
                  e = exp_wr.pop_front();
                  check("waddr", waddr, e.addr);
                  check("wdata", wdata, e.data);
                  $display("write addr=%h data=%h", waddr, wdata);
               end
            end
            if (ren) begin
               rd_cnt++;
               check("raddr", raddr, 32'h0);
            end
            if (prev_done != '0) check("done_one_cycle", 32'(done), 32'd0);
            if (done != '0) begin
               if (exp_done.size() == 0) begin
                  check("done_expected", 32'd0, 32'd1);
               end else begin
                  d = exp_done.pop_front();
                  m = '0;
                  m[d.id] = 1'b1;
                  check("done_vec", 32'(done), 32'(m));
                  check("done_grant_id", 32'(grant_id), 32'(d.id));
                  check("done_err", 32'(err), 32'(d.err));
                  check("done_busy_low", 32'(busy), 32'd0);
                  $display("done id=%0d err=%0b", grant_id, err);
               end
               done_cnt++;
            end else if (err) begin
               check("err_without_done", 32'(err), 32'd0);
            end
            prev_done = done;
         end
      end
   end

   // Stimulus.
   initial begin
      vec_t         vecs[6];
      int           target;
      int           rd0;
      int           id;
      int           k;
      logic [N-1:0] m;

      vecs[0] = '{id: 1, dly: 32'd5, bp: 1'b0};
      vecs[1] = '{id: 2, dly: 32'd0, bp: 1'b0};
      vecs[2] = '{id: 3, dly: 32'd3, bp: 1'b1};
      vecs[3] = '{id: 1, dly: 32'd6, bp: 1'b0};
      vecs[4] = '{id: 2, dly: 32'd2, bp: 1'b1};
      vecs[5] = '{id: 0, dly: 32'd1, bp: 1'b1};

      target     = 0;
      rstn       = 1'b0;
      req        = '0;
      req_delay  = '0;
      bp_mode    = 1'b0;
      never_done = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wen", 32'(wen), 32'd0);
      check("rst_ren", 32'(ren), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_wstrb", 32'(wstrb), 32'd0);
      rstn = 1'b1;

      // Round robin with every requester active: 0,1,2,3,0.
      for (int i = 0; i < N; i++) req_delay[32*i +: 32] = 32'd2;
      for (int j = 0; j < 5; j++) push_seq(j % N, 32'd2, 1'b0);
      @(posedge clk);
      #1 req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         target++;
         wait_done(target);
         #1;
         if (j == 4) req = '0;
         else begin
            req[j % N] = 1'b0;
            @(posedge clk);
            #1 req[j % N] = 1'b1;
         end
      end
      repeat (3) @(posedge clk);
      check("rr_wr_drained", 32'(exp_wr.size()), 32'd0);

      // Single requests from the vector table.
      for (int v = 0; v < 6; v++) begin
         id      = vecs[v].id;
         bp_mode = vecs[v].bp;
         req_delay[32*id +: 32] = vecs[v].dly;
         push_seq(id, vecs[v].dly, 1'b0);
         rd0 = rd_cnt;
         m = '0;
         m[id] = 1'b1;
         @(posedge clk);
         #1 req[id] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("busy_rise", 32'(busy), 32'd1);
         check("grant_id", 32'(grant_id), 32'(id));
         check("wen_not_yet", 32'(wen), 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("wen_rise", 32'(wen), 32'(vecs[v].dly != 32'd0));
         check("zero_dly_done", 32'(done), (vecs[v].dly == 32'd0) ? 32'(m) : 32'd0);
         target++;
         wait_done(target);
         #1 req[id] = 1'b0;
         repeat (3) @(posedge clk);
         if (vecs[v].dly == 32'd0) check("zero_dly_no_reads", 32'(rd_cnt - rd0), 32'd0);
         check("vec_wr_drained", 32'(exp_wr.size()), 32'd0);
      end
      bp_mode = 1'b0;

      // Reset while waiting for read data; req[0] wins afterwards.
      req_delay[31:0] = 32'd40;
      push_seq(0, 32'd40, 1'b0);
      @(posedge clk);
      #1 req[0] = 1'b1;
      k = 0;
      while (!ren && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("mid_poll_ren_seen", 32'(ren), 32'd1);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_ren", 32'(ren), 32'd0);
      check("arst_raddr", raddr, 32'd0);
      check("arst_grant_id", 32'(grant_id), 32'd0);
      check("arst_wen", 32'(wen), 32'd0);
      exp_wr.delete();
      exp_done.delete();
      req = '0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      req_delay[31:0]  = 32'd2;
      req_delay[63:32] = 32'd2;
      push_seq(0, 32'd2, 1'b0);
      push_seq(1, 32'd2, 1'b0);
      @(posedge clk);
      #1 req = 4'b0011;
      target++;
      wait_done(target);
      #1 req[0] = 1'b0;
      target++;
      wait_done(target);
      #1 req[1] = 1'b0;
      repeat (3) @(posedge clk);

`ifdef TIMER_SCHED_TIMEOUT_EN
      // Timer never reports done: exactly MAX_POLLS reads, then disable.
      never_done = 1'b1;
      req_delay[32*3 +: 32] = 32'd10;
      push_seq(3, 32'd10, 1'b1);
      rd0 = rd_cnt;
      @(posedge clk);
      #1 req[3] = 1'b1;
      target++;
      wait_done(target);
      #1 req[3] = 1'b0;
      check("timeout_reads", 32'(rd_cnt - rd0), 32'd4);
      never_done = 1'b0;
      repeat (3) @(posedge clk);
`endif

      check("final_wr_drained", 32'(exp_wr.size()), 32'd0);
      check("final_done_drained", 32'(exp_done.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares the single timer core (timer0 one-shot delay) among N requesters. It grants one requester at a time and programs the delay and enable bits over the timer's register write port. It then polls the done flag over the read port, clears the enable, and returns a one-cycle completion pulse to the granted requester. It sits between the CPU-side/peripheral requesters and the timer core's register interface, as the only master of that interface.

## Interface
- N, 4: number of requesters (2..8)
- CTRL_ADDR, 32'h0000_0000: timer control register address
- DELAY_ADDR, 32'h0000_0004: timer0 delay register address
- EN_BIT, 0: tmr_en bit position in control register
- DONE_BIT, 2: tmr_done bit position in control register
- MAX_POLLS, 16'hFFFF: poll limit (used only with timeout feature)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  N  per-requester request, level
- req_delay  in  32*N  per-requester delay; slice i = [32*i+31:32*i]
- done  out  N  one-cycle completion pulse, one-hot
- err  out  1  one-cycle timeout flag, coincident with done
- busy  out  1  a grant is active
- grant_id  out  3  index of current/last granted requester
- waddr  out  32  timer register write address
- wdata  out  32  write data
- wen  out  1  write request
- wstrb  out  4  byte strobes, always 4'hF when wen=1
- wready  in  1  write accepted
- raddr  out  32  read address
- ren  out  1  read request
- rdata  in  32  read data
- rvalid  in  1  read data valid

## Operation
- States: IDLE, GRANT, WR_DLY, WR_EN, RD_REQ, RD_WAIT, WR_DIS, DONE.
- IDLE: if any req bit is high, go to GRANT. Arbitration is round-robin: the search starts at (last granted + 1) mod N. After reset the pointer makes index 0 highest priority.
- GRANT: register grant_id and the selected req_delay slice. Set busy=1.
  - Latched delay == 0: go directly to DONE; the timer is not touched.
  - Otherwise go to WR_DLY.
- WR_DLY: wen=1, waddr=DELAY_ADDR, wdata=latched delay. Hold until wready=1, then go to WR_EN.
- WR_EN: wen=1, waddr=CTRL_ADDR, wdata=1<<EN_BIT. Hold until wready=1, then go to RD_REQ.
- RD_REQ: ren=1 for exactly one cycle, raddr=CTRL_ADDR, then go to RD_WAIT.
- RD_WAIT: wait for rvalid. When rvalid=1:
  - rdata[DONE_BIT]=1: go to WR_DIS.
  - Otherwise go back to RD_REQ.
- WR_DIS: wen=1, waddr=CTRL_ADDR, wdata=0. Hold until wready=1, then go to DONE.
- DONE: done[grant_id]=1 for one cycle, busy=0, advance the RR pointer, go to IDLE.
- Requester contract: keep req high until its done pulse and drop it the cycle after. req still high in the cycle after done is a new request. req_delay changes after GRANT are ignored.
- req deasserted while granted: the sequence still completes and done still pulses.
- Bus write completes in the cycle where wen & wready are both 1. waddr/wdata are stable while wen=1. wen and ren are never both high.

## Timing
- Reset values: done=0, err=0, busy=0, grant_id=0, wen=0, ren=0, waddr=0, wdata=0, wstrb=0, raddr=0. State=IDLE, RR pointer=N-1.
- All outputs are registered.
- From req high in IDLE: busy rises 1 cycle later (GRANT), and wen rises 2 cycles later.
- Zero-delay path: done pulses 2 cycles after req is seen in IDLE.
- Minimum poll iteration is 2 cycles (RD_REQ + 1 cycle rvalid).
- Reset mid-sequence returns to IDLE immediately. The timer may be left enabled; software must re-initialise it.
- Simultaneous requests: exactly one grant per sequence; the others wait. No requester waits for more than N-1 other grants.

## Configuration
- Macro: TIMER_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit poll counter clears in GRANT and increments on each RD_REQ.
  - When it reaches MAX_POLLS without seeing done, go to WR_DIS. err then pulses with done.
- Undefined: polling is unbounded and err is tied to 0.

## Test plan
- Single request: req[1]=1, delay=5, wready/rvalid always high. Expect writes DELAY_ADDR<=5, CTRL_ADDR<=1, polls until DONE_BIT is set, then CTRL_ADDR<=0. done=4'b0010 for one cycle, grant_id=1.
- Round-robin: req=4'b1111 held, re-raised after each done. Grant order is 0,1,2,3,0.
- Zero delay: req[2]=1, delay=0. Expect no wen/ren, and done[2] pulses 2 cycles after req.
- Backpressure: wready low for 3 cycles on every write. wen, waddr and wdata stay stable; the sequence completes with the correct order.
- Reset mid-poll: assert rstn=0 in RD_WAIT. All outputs return to reset values asynchronously. After release, a new req[0] is granted first.
- Timeout (macro defined, MAX_POLLS=4): done never set. Expect exactly 4 reads, then CTRL_ADDR<=0, with done and err pulsing together.
